uart_price_frame_decoder: RTL and testbench

- Replaces the plain two-byte concatenator between the UART receive path and the trading algorithm.
- Takes received UART bytes and finds 4-byte price frames: SOF, price high byte, price low byte, checksum.
- Validates each frame, then delivers a 16-bit price with a one-cycle valid strobe to the algorithm's w_increase/data_in inputs.
- Recovers from corrupted, truncated or stalled frames and keeps error and frame statistics.

---
 rtl/uart_price_frame_decoder_if.sv | 21 ++
 rtl/uart_price_frame_decoder.sv | 92 +++++++++
 tb/tb_uart_price_frame_decoder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uart_price_frame_decoder_if.sv
// rtl/uart_price_frame_decoder_if.sv - UART byte input and decoded price/statistics bundle
interface uart_price_frame_decoder_if;
    logic [7:0]  rx_data;
    logic        rx_data_valid;
    logic [15:0] price;
    logic        price_valid;
    logic        frame_err;
    logic [7:0]  err_count;
    logic [15:0] frame_count;
    logic        busy;

    modport master (
        output rx_data, rx_data_valid,
        input  price, price_valid, frame_err, err_count, frame_count, busy
    );

    modport slave (
        input  rx_data, rx_data_valid,
        output price, price_valid, frame_err, err_count, frame_count, busy
    );
endinterface

// File: rtl/uart_price_frame_decoder.sv
// rtl/uart_price_frame_decoder.sv - SOF/hi/lo/xor-checksum price frame decoder with timeout and stats
module uart_price_frame_decoder #(
    parameter logic [7:0] SOF_BYTE       = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         TO_W           = 17,
    parameter int         EDGE_DETECT    = 1
) (
    input  logic clk,
    input  logic rst,
    uart_price_frame_decoder_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_CHK} state_t;

    state_t          state, state_nxt;
    logic            valid_d;
    logic            acc;
    logic            timeout;
    logic            good_nxt, bad_nxt;
    logic [7:0]      hi_r, lo_r;
    logic [TO_W-1:0] to_cnt;
    logic [15:0]     price_r;
    logic            price_valid_r, frame_err_r, busy_r;
    logic [7:0]      err_count_r;
    logic [15:0]     frame_count_r;

    // valid_d resets high so a strobe level held through reset is not a new byte
    assign acc = bus.rx_data_valid & ((EDGE_DETECT == 0) | ~valid_d);

    assign timeout = (state != S_IDLE) && !acc &&
                     (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        good_nxt  = 1'b0;
        bad_nxt   = 1'b0;
        case (state)
            S_IDLE: if (acc && bus.rx_data == SOF_BYTE) state_nxt = S_HI;
            S_HI:   if (acc) state_nxt = S_LO;
            S_LO:   if (acc) state_nxt = S_CHK;
            S_CHK: begin
                if (acc) begin
                    state_nxt = S_IDLE;
                    if (bus.rx_data == (hi_r ^ lo_r)) good_nxt = 1'b1;
                    else                              bad_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (timeout) begin
            state_nxt = S_IDLE;
            bad_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            valid_d       <= 1'b1;
            hi_r          <= 8'h00;
            lo_r          <= 8'h00;
            to_cnt        <= '0;
            price_r       <= 16'h0000;
            price_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            err_count_r   <= 8'h00;
            frame_count_r <= 16'h0000;
            busy_r        <= 1'b0;
        end else begin
            state         <= state_nxt;
            valid_d       <= bus.rx_data_valid;
            busy_r        <= (state_nxt != S_IDLE);
            price_valid_r <= good_nxt;
            frame_err_r   <= bad_nxt;
            if (acc && state == S_HI) hi_r <= bus.rx_data;
            if (acc && state == S_LO) lo_r <= bus.rx_data;
            if (acc || state == S_IDLE) to_cnt <= '0;
            else                        to_cnt <= to_cnt + 1'b1;
            if (good_nxt) begin
                price_r       <= {hi_r, lo_r};
                frame_count_r <= frame_count_r + 16'h0001;
            end
            if (bad_nxt && err_count_r != 8'hFF) err_count_r <= err_count_r + 8'h01;
        end
    end

    assign bus.price       = price_r;
    assign bus.price_valid = price_valid_r;
    assign bus.frame_err   = frame_err_r;
    assign bus.err_count   = err_count_r;
    assign bus.frame_count = frame_count_r;
    assign bus.busy        = busy_r;
endmodule

// File: tb/tb_uart_price_frame_decoder.sv
// tb/tb_uart_price_frame_decoder.sv - directed self-checking bench for uart_price_frame_decoder
module tb_uart_price_frame_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   pv_cnt = 0, fe_cnt = 0, both_cnt = 0, fe0_cnt = 0;

    uart_price_frame_decoder_if bus ();
    uart_price_frame_decoder_if bus0 ();

    uart_price_frame_decoder #(.SOF_BYTE(8'hA5), .TIMEOUT_CYCLES(16), .TO_W(5), .EDGE_DETECT(1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    uart_price_frame_decoder #(.SOF_BYTE(8'hA5), .TIMEOUT_CYCLES(16), .TO_W(5), .EDGE_DETECT(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.price_valid) pv_cnt++;
        if (bus.frame_err) fe_cnt++;
        if (bus.price_valid && bus.frame_err) both_cnt++;
        if (bus0.frame_err) fe0_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int hold);
        bus.rx_data = b;
        bus.rx_data_valid = 1'b1;
        repeat (hold) @(negedge clk);
        bus.rx_data_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] h, input logic [7:0] l, input logic [7:0] c);
        send(8'hA5, 1);
        send(h, 1);
        send(l, 1);
        send(c, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.rx_data_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int p0, f0, n;
        bus.rx_data = 8'h00;
        bus.rx_data_valid = 1'b0;
        bus0.rx_data = 8'h00;
        bus0.rx_data_valid = 1'b0;
        do_reset();

        check("rst_price", bus.price, 16'h0000);
        check("rst_pv", bus.price_valid, 1'b0);
        check("rst_fe", bus.frame_err, 1'b0);
        check("rst_errcnt", bus.err_count, 8'h00);
        check("rst_framecnt", bus.frame_count, 16'h0000);
        check("rst_busy", bus.busy, 1'b0);

        // good frame, strobes held 5 cycles, checksum latency checked by hand
        send(8'hA5, 5);
        check("busy_in_frame", bus.busy, 1'b1);
        send(8'h12, 5);
        send(8'h34, 5);
        bus.rx_data = 8'h26;
        bus.rx_data_valid = 1'b1;
        @(negedge clk);
        check("good_pv_latency", bus.price_valid, 1'b1);
        check("good_price", bus.price, 16'h1234);
        @(negedge clk);
        check("good_pv_width", bus.price_valid, 1'b0);
        repeat (3) @(negedge clk);
        bus.rx_data_valid = 1'b0;
        @(negedge clk);
        check("good_pv_count", pv_cnt, 1);
        check("good_framecnt", bus.frame_count, 16'h0001);
        check("good_errcnt", bus.err_count, 8'h00);

        // bad checksum
        p0 = pv_cnt; f0 = fe_cnt;
        frame(8'h12, 8'h34, 8'h00);
        @(negedge clk);
        check("badck_fe_count", fe_cnt - f0, 1);
        check("badck_errcnt", bus.err_count, 8'h01);
        check("badck_price", bus.price, 16'h1234);
        check("badck_no_pv", pv_cnt - p0, 0);
        check("badck_busy", bus.busy, 1'b0);

        // garbage before SOF, SOF inside frame taken as data
        p0 = pv_cnt; f0 = fe_cnt;
        send(8'h00, 1); send(8'hFF, 1);
        check("garbage_idle", bus.busy, 1'b0);
        send(8'hA5, 1); send(8'hA5, 1); send(8'h00, 1); send(8'hA5, 1);
        check("resync_price", bus.price, 16'hA500);
        check("resync_pv_count", pv_cnt - p0, 1);
        check("resync_no_fe", fe_cnt - f0, 0);

        // timeout: 16 idle cycles after the hi byte
        f0 = fe_cnt;
        send(8'hA5, 1);
        bus.rx_data = 8'h12;
        bus.rx_data_valid = 1'b1;
        @(negedge clk);
        bus.rx_data_valid = 1'b0;
        n = 40;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.frame_err) begin
                n = i;
                break;
            end
        end
        check("timeout_cycle", n, 16);
        check("timeout_busy", bus.busy, 1'b0);
        check("timeout_errcnt", bus.err_count, 8'h02);
        frame(8'h00, 8'h01, 8'h01);
        check("after_timeout_price", bus.price, 16'h0001);
        check("timeout_fe_count", fe_cnt - f0, 1);

        // err_count saturation
        do_reset();
        for (int i = 1; i <= 260; i++) begin
            frame(8'h11, 8'h22, 8'h00);
            if (i == 254) check("sat_254", bus.err_count, 8'hFE);
        end
        check("sat_260", bus.err_count, 8'hFF);

        // frame_count wrap
        force dut.frame_count_r = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count_r;
        @(negedge clk);
        check("preload_framecnt", bus.frame_count, 16'hFFFF);
        frame(8'h55, 8'h0F, 8'h5A);
        check("wrap_framecnt", bus.frame_count, 16'h0000);
        check("wrap_price", bus.price, 16'h550F);

        // mid-frame reset discards the partial frame
        p0 = pv_cnt; f0 = fe_cnt;
        send(8'hA5, 1); send(8'h12, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send(8'h34, 1); send(8'h26, 1);
        repeat (2) @(negedge clk);
        check("midrst_no_pv", pv_cnt - p0, 0);
        check("midrst_no_fe", fe_cnt - f0, 0);
        check("midrst_price", bus.price, 16'h0000);
        check("midrst_framecnt", bus.frame_count, 16'h0000);
        check("midrst_errcnt", bus.err_count, 8'h00);
        check("midrst_busy", bus.busy, 1'b0);

        // level mode: A5 held four cycles is four bytes with a bad checksum
        f0 = fe0_cnt;
        bus0.rx_data = 8'hA5;
        bus0.rx_data_valid = 1'b1;
        repeat (4) @(negedge clk);
        bus0.rx_data_valid = 1'b0;
        check("level_fe_pulse", bus0.frame_err, 1'b1);
        @(negedge clk);
        check("level_fe_count", fe0_cnt - f0, 1);
        check("level_errcnt", bus0.err_count, 8'h01);
        check("level_framecnt", bus0.frame_count, 16'h0000);
        check("level_busy", bus0.busy, 1'b0);

        check("never_both", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
